whack_game_ctrl: RTL and testbench

- Parametrised N-channel whack-a-lamp game engine: lamps light on per-channel timers, player hits active-low buttons, score tracked with win/lose detection.
- Sits between the board I/O (buttons, lamps) and the VGA/score display, which consume score, in_game and the result flags.
- Successor to the fixed 4-button controller:
  - channel count and timing are generalised;
  - inputs are synchronised;
  - simultaneous events are resolved deterministically;
  - a lose condition is added.

---
 rtl/whack_game_ctrl_if.sv | 52 +++++
 rtl/whack_game_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_whack_game_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/whack_game_ctrl_if.sv
// Board/display side signals of the whack-a-lamp game engine.
// WHACK_FALSE_HIT_PENALTY_EN adds the false_hit_pulse signal.
interface whack_game_ctrl_if #(
  parameter int NUM_CH  = 4,
  parameter int SCORE_W = 8
);
  logic               tick_en;
  logic [NUM_CH-1:0]  btn_n;
  logic               start_n;
  logic [NUM_CH-1:0]  lamp;
  logic [SCORE_W-1:0] score;
  logic               in_game;
  logic               game_won;
  logic               game_lost;
  logic [NUM_CH-1:0]  hit_pulse;
  logic [NUM_CH-1:0]  miss_pulse;
`ifdef WHACK_FALSE_HIT_PENALTY_EN
  logic [NUM_CH-1:0]  false_hit_pulse;
`endif

  modport master (
    output tick_en,
    output btn_n,
    output start_n,
    input  lamp,
    input  score,
    input  in_game,
    input  game_won,
    input  game_lost,
    input  hit_pulse,
`ifdef WHACK_FALSE_HIT_PENALTY_EN
    input  false_hit_pulse,
`endif
    input  miss_pulse
  );

  modport slave (
    input  tick_en,
    input  btn_n,
    input  start_n,
    output lamp,
    output score,
    output in_game,
    output game_won,
    output game_lost,
    output hit_pulse,
`ifdef WHACK_FALSE_HIT_PENALTY_EN
    output false_hit_pulse,
`endif
    output miss_pulse
  );
endinterface

// File: rtl/whack_game_ctrl.sv
// N-channel whack-a-lamp engine: synchronised buttons, per-channel lit/dark timers, clamped score.
// Optional WHACK_FALSE_HIT_PENALTY_EN: presses on dark channels cost one point.
module whack_game_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 28,
  parameter int SCORE_W     = 8,
  parameter int START_SCORE = 3,
  parameter int WIN_SCORE   = 12,
  parameter int LIT_TICKS   = 50,
  parameter int DARK_BASE   = 100,
  parameter int DARK_STEP   = 25
) (
  input  logic             clk,
  input  logic             reset,
  whack_game_ctrl_if.slave io
);
  localparam int DW = SCORE_W + 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_OVER
  } state_e;

  state_e state_q, state_d;

  logic [NUM_CH:0] sync1_q, sync2_q, prev_q;
  logic [NUM_CH:0] press;
  logic            start_press;

  logic [NUM_CH-1:0]  lit_q, lit_d;
  logic [CNT_W-1:0]   cnt_q [NUM_CH];
  logic [CNT_W-1:0]   cnt_d [NUM_CH];
  logic [SCORE_W-1:0] score_q, score_d;
  logic               won_q, won_d;
  logic               lost_q, lost_d;
  logic [NUM_CH-1:0]  hit_q, hit_d;
  logic [NUM_CH-1:0]  miss_q, miss_d;

  logic signed [DW-1:0] n_hit, n_miss, delta, sum;

`ifdef WHACK_FALSE_HIT_PENALTY_EN
  logic [NUM_CH-1:0]    fhit_q, fhit_d;
  logic signed [DW-1:0] n_fhit;
`endif

  // Bit NUM_CH carries the start button alongside the channel buttons
  assign press       = prev_q & ~sync2_q;
  assign start_press = press[NUM_CH];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
      state_q <= ST_IDLE;
      lit_q   <= '0;
      cnt_q   <= '{default: '0};
      score_q <= '0;
      won_q   <= 1'b0;
      lost_q  <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
`ifdef WHACK_FALSE_HIT_PENALTY_EN
      fhit_q  <= '0;
`endif
    end else begin
      sync1_q <= {io.start_n, io.btn_n};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      lit_q   <= lit_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      won_q   <= won_d;
      lost_q  <= lost_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
`ifdef WHACK_FALSE_HIT_PENALTY_EN
      fhit_q  <= fhit_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    lit_d   = lit_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    won_d   = won_q;
    lost_d  = lost_q;
    hit_d   = '0;
    miss_d  = '0;
    n_hit   = '0;
    n_miss  = '0;
    delta   = '0;
    sum     = '0;
`ifdef WHACK_FALSE_HIT_PENALTY_EN
    fhit_d  = '0;
    n_fhit  = '0;
`endif
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_press) begin
          state_d = ST_PLAY;
          lit_d   = '0;
          cnt_d   = '{default: '0};
          score_d = SCORE_W'(START_SCORE);
          won_d   = 1'b0;
          lost_d  = 1'b0;
        end
      end
      ST_PLAY: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (lit_q[i]) begin
            // A press beats a timeout landing on the same edge
            if (press[i]) begin
              lit_d[i] = 1'b0;
              cnt_d[i] = '0;
              hit_d[i] = 1'b1;
            end else if (io.tick_en) begin
              if (cnt_q[i] == CNT_W'(LIT_TICKS - 1)) begin
                lit_d[i]  = 1'b0;
                cnt_d[i]  = '0;
                miss_d[i] = 1'b1;
              end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
              end
            end
          end else begin
`ifdef WHACK_FALSE_HIT_PENALTY_EN
            if (press[i]) fhit_d[i] = 1'b1;
`endif
            if (io.tick_en) begin
              if (cnt_q[i] == CNT_W'(DARK_BASE + i * DARK_STEP - 1)) begin
                lit_d[i] = 1'b1;
                cnt_d[i] = '0;
              end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
              end
            end
          end
          n_hit  = n_hit + DW'(hit_d[i]);
          n_miss = n_miss + DW'(miss_d[i]);
`ifdef WHACK_FALSE_HIT_PENALTY_EN
          n_fhit = n_fhit + DW'(fhit_d[i]);
`endif
        end
`ifdef WHACK_FALSE_HIT_PENALTY_EN
        delta = n_hit - n_miss - n_fhit;
`else
        delta = n_hit - n_miss;
`endif
        sum = $signed({5'b0, score_q}) + delta;
        if (sum < 0) begin
          score_d = '0;
        end else if (sum > $signed({5'b0, {SCORE_W{1'b1}}})) begin
          score_d = '1;
        end else begin
          score_d = sum[SCORE_W-1:0];
        end
        if (score_d >= SCORE_W'(WIN_SCORE)) begin
          state_d = ST_OVER;
          won_d   = 1'b1;
        end else if (score_d == '0 && delta < 0) begin
          state_d = ST_OVER;
          lost_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign io.lamp = (state_q == ST_PLAY) ? lit_q :
                   (state_q == ST_OVER && won_q) ? '1 : '0;
  assign io.score      = score_q;
  assign io.in_game    = (state_q == ST_PLAY);
  assign io.game_won   = won_q;
  assign io.game_lost  = lost_q;
  assign io.hit_pulse  = hit_q;
  assign io.miss_pulse = miss_q;
`ifdef WHACK_FALSE_HIT_PENALTY_EN
  assign io.false_hit_pulse = fhit_q;
`endif
endmodule

// File: tb/tb_whack_game_ctrl.sv
// Directed bench for whack_game_ctrl: 4 channels, lit 4, dark 6+2*i, tick every cycle.
// Positions p are counted in edges after the start-press edge (p=0).
module tb_whack_game_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

`ifdef WHACK_FALSE_HIT_PENALTY_EN
  localparam int LOSE_P = 12;
`else
  localparam int LOSE_P = 14;
`endif

  whack_game_ctrl_if #(.NUM_CH(4), .SCORE_W(8)) io ();

  whack_game_ctrl #(
    .NUM_CH(4), .CNT_W(8), .SCORE_W(8),
    .START_SCORE(3), .WIN_SCORE(12),
    .LIT_TICKS(4), .DARK_BASE(6), .DARK_STEP(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(io)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    reset = 1'b1;
    io.tick_en = 1'b1;
    io.start_n = 1'b1;
    io.btn_n = 4'hF;
    step(2);
    reset = 1'b0;
    step(2);
    io.start_n = 1'b0;
    step(3);
    io.start_n = 1'b1;
  endtask

  task automatic test_reset();
    io.tick_en = 1'b1;
    io.start_n = 1'b1;
    io.btn_n = 4'hF;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      checks++;
      if ({io.lamp, io.score, io.in_game, io.game_won, io.game_lost,
           io.hit_pulse, io.miss_pulse} !== 23'd0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d lamp=%b score=%0d in_game=%b hit=%b miss=%b exp all 0",
                 k, io.lamp, io.score, io.in_game, io.hit_pulse, io.miss_pulse);
      end
    end
  endtask

  task automatic test_start_miss();
    start_game();
    checks++;
    if ({io.in_game, io.score, io.lamp} !== {1'b1, 8'd3, 4'h0}) begin
      failures++;
      $display("FAIL start in_game=%b score=%0d lamp=%b exp 1/3/0000",
               io.in_game, io.score, io.lamp);
    end
    step(1);
    io.start_n = 1'b0;
    step(2);
    io.start_n = 1'b1;
    step(2);
    checks++;
    if (io.lamp !== 4'b0000 || io.score !== 8'd3) begin
      failures++;
      $display("FAIL p5_dark lamp=%b score=%0d exp 0000/3", io.lamp, io.score);
    end
    step(1);
    checks++;
    if (io.lamp !== 4'b0001) begin
      failures++;
      $display("FAIL p6_lamp0 got=%b exp=0001", io.lamp);
    end
    step(4);
    checks++;
    if ({io.lamp, io.miss_pulse, io.score} !== {4'b0110, 4'b0001, 8'd2}) begin
      failures++;
      $display("FAIL p10_miss0 lamp=%b miss=%b score=%0d exp 0110/0001/2",
               io.lamp, io.miss_pulse, io.score);
    end
    step(1);
    checks++;
    if (io.miss_pulse !== 4'b0000 || io.score !== 8'd2) begin
      failures++;
      $display("FAIL p11_pulse miss=%b score=%0d exp 0000/2", io.miss_pulse, io.score);
    end
    step(1);
    checks++;
    if ({io.lamp, io.miss_pulse, io.score} !== {4'b1100, 4'b0010, 8'd1}) begin
      failures++;
      $display("FAIL p12_lamp3 lamp=%b miss=%b score=%0d exp 1100/0010/1",
               io.lamp, io.miss_pulse, io.score);
    end
  endtask

  task automatic test_hit_hold();
    int extra;
    extra = 0;
    start_game();
    step(6);
    io.btn_n = 4'hE;
    step(2);
    checks++;
    if (io.lamp !== 4'b0011 || io.score !== 8'd3) begin
      failures++;
      $display("FAIL p8_prehit lamp=%b score=%0d exp 0011/3", io.lamp, io.score);
    end
    step(1);
    checks++;
    if ({io.lamp, io.hit_pulse, io.score} !== {4'b0010, 4'b0001, 8'd4}) begin
      failures++;
      $display("FAIL p9_hit lamp=%b hit=%b score=%0d exp 0010/0001/4",
               io.lamp, io.hit_pulse, io.score);
    end
    for (int p = 10; p <= 18; p++) begin
      step(1);
      if (io.hit_pulse[0]) extra++;
    end
    checks++;
    if (io.lamp !== 4'b0001 || io.score !== 8'd1) begin
      failures++;
      $display("FAIL p18_relit lamp=%b score=%0d exp 0001/1", io.lamp, io.score);
    end
    step(1);
    if (io.hit_pulse[0]) extra++;
    checks++;
    if ({io.game_lost, io.in_game, io.score, io.lamp, io.miss_pulse} !==
        {1'b1, 1'b0, 8'd0, 4'b0000, 4'b0001}) begin
      failures++;
      $display("FAIL p19_lost lost=%b in_game=%b score=%0d lamp=%b miss=%b exp 1/0/0/0000/0001",
               io.game_lost, io.in_game, io.score, io.lamp, io.miss_pulse);
    end
    for (int p = 20; p <= 59; p++) begin
      step(1);
      if (io.hit_pulse[0]) extra++;
    end
    io.btn_n = 4'hF;
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL hold_single got=%0d extra hits exp=0", extra);
    end
  endtask

  task automatic test_hit_timeout_tie();
    start_game();
    step(7);
    io.btn_n = 4'hE;
    step(2);
    checks++;
    if (io.lamp !== 4'b0011 || io.score !== 8'd3) begin
      failures++;
      $display("FAIL tie_pre lamp=%b score=%0d exp 0011/3", io.lamp, io.score);
    end
    step(1);
    io.btn_n = 4'hF;
    checks++;
    if ({io.hit_pulse, io.miss_pulse, io.score, io.lamp} !==
        {4'b0001, 4'b0000, 8'd4, 4'b0110}) begin
      failures++;
      $display("FAIL tie_hit hit=%b miss=%b score=%0d lamp=%b exp 0001/0000/4/0110",
               io.hit_pulse, io.miss_pulse, io.score, io.lamp);
    end
  endtask

  task automatic test_back_to_back();
    start_game();
    step(6);
    io.btn_n = 4'hE;
    step(3);
    checks++;
    if (io.hit_pulse !== 4'b0001 || io.score !== 8'd4) begin
      failures++;
      $display("FAIL b2b_hit0 hit=%b score=%0d exp 0001/4", io.hit_pulse, io.score);
    end
    io.btn_n = 4'hB;
    step(2);
    checks++;
    if (io.lamp !== 4'b0110 || io.score !== 8'd4) begin
      failures++;
      $display("FAIL b2b_pre lamp=%b score=%0d exp 0110/4", io.lamp, io.score);
    end
    step(1);
    io.btn_n = 4'hF;
    checks++;
    if ({io.hit_pulse, io.miss_pulse, io.score, io.lamp} !==
        {4'b0100, 4'b0010, 8'd4, 4'b1000}) begin
      failures++;
      $display("FAIL b2b_same hit=%b miss=%b score=%0d lamp=%b exp 0100/0010/4/1000",
               io.hit_pulse, io.miss_pulse, io.score, io.lamp);
    end
  endtask

  task automatic test_win_lose();
    int cur;
    start_game();
    for (int p = 1; p <= 30; p++) begin
      step(1);
      if (p == 29) begin
        checks++;
        if (io.score !== 8'd11 || io.in_game !== 1'b1) begin
          failures++;
          $display("FAIL p29_score got=%0d in_game=%b exp 11/1", io.score, io.in_game);
        end
      end
      if (p < 30) io.btn_n = ~io.lamp;
    end
    io.btn_n = 4'hF;
    checks++;
    if ({io.game_won, io.game_lost, io.in_game, io.lamp, io.score, io.hit_pulse} !==
        {3'b100, 4'hF, 8'd12, 4'b1000}) begin
      failures++;
      $display("FAIL win won=%b lost=%b in_game=%b lamp=%b score=%0d hit=%b exp 1/0/0/1111/12/1000",
               io.game_won, io.game_lost, io.in_game, io.lamp, io.score, io.hit_pulse);
    end
    step(3);
    checks++;
    if (io.game_won !== 1'b1 || io.lamp !== 4'hF || io.score !== 8'd12) begin
      failures++;
      $display("FAIL win_hold won=%b lamp=%b score=%0d exp 1/1111/12",
               io.game_won, io.lamp, io.score);
    end
    io.start_n = 1'b0;
    step(3);
    io.start_n = 1'b1;
    checks++;
    if ({io.in_game, io.game_won, io.game_lost, io.score} !== {3'b100, 8'd3}) begin
      failures++;
      $display("FAIL restart_won in_game=%b won=%b lost=%b score=%0d exp 1/0/0/3",
               io.in_game, io.game_won, io.game_lost, io.score);
    end
    cur = 0;
`ifdef WHACK_FALSE_HIT_PENALTY_EN
    io.btn_n = 4'hD;
    step(3);
    io.btn_n = 4'hF;
    cur = 3;
    checks++;
    if ({io.score, io.false_hit_pulse, io.miss_pulse, io.hit_pulse} !==
        {8'd2, 4'b0010, 4'b0000, 4'b0000}) begin
      failures++;
      $display("FAIL false_hit score=%0d fhit=%b miss=%b hit=%b exp 2/0010/0000/0000",
               io.score, io.false_hit_pulse, io.miss_pulse, io.hit_pulse);
    end
`endif
    step(LOSE_P - 1 - cur);
    checks++;
    if (io.score !== 8'd1 || io.in_game !== 1'b1) begin
      failures++;
      $display("FAIL prelose score=%0d in_game=%b exp 1/1", io.score, io.in_game);
    end
    step(1);
    checks++;
    if ({io.game_lost, io.game_won, io.in_game, io.lamp, io.score} !==
        {3'b100, 4'h0, 8'd0}) begin
      failures++;
      $display("FAIL lose lost=%b won=%b in_game=%b lamp=%b score=%0d exp 1/0/0/0000/0",
               io.game_lost, io.game_won, io.in_game, io.lamp, io.score);
    end
    io.start_n = 1'b0;
    step(3);
    io.start_n = 1'b1;
    checks++;
    if ({io.in_game, io.game_won, io.game_lost, io.score} !== {3'b100, 8'd3}) begin
      failures++;
      $display("FAIL restart_lost in_game=%b won=%b lost=%b score=%0d exp 1/0/0/3",
               io.in_game, io.game_won, io.game_lost, io.score);
    end
  endtask

  task automatic test_reset_mid();
    start_game();
    step(9);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++;
    if ({io.lamp, io.score, io.in_game, io.hit_pulse, io.miss_pulse} !== 21'd0) begin
      failures++;
      $display("FAIL reset_mid lamp=%b score=%0d in_game=%b hit=%b miss=%b exp all 0",
               io.lamp, io.score, io.in_game, io.hit_pulse, io.miss_pulse);
    end
    step(5);
    checks++;
    if (io.in_game !== 1'b0 || io.lamp !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_idle in_game=%b lamp=%b exp 0/0000", io.in_game, io.lamp);
    end
  endtask

  initial begin
    test_reset();
    test_start_miss();
    test_hit_hold();
    test_hit_timeout_tie();
    test_back_to_back();
    test_win_lose();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
